// File: rtl/pingpong_fifo_reader.sv
// Ping-pong FIFO read controller: drains fifo1/fifo2 on alternate lines,
// expands RGB565 to RGB888 and streams pixels through a 2-entry skid buffer.
module pingpong_fifo_reader #(
  parameter int LINE_PIXELS = 800,
  parameter int FRAME_LINES = 480,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_frame_start,
  input  logic             i_work_en,
  input  logic             i_fifo1_empty,
  output logic             o_fifo1_rd_en,
  input  logic [15:0]      i_fifo1_rd_data,
  input  logic             i_fifo1_rd_data_vld,
  input  logic             i_fifo2_empty,
  output logic             o_fifo2_rd_en,
  input  logic [15:0]      i_fifo2_rd_data,
  input  logic             i_fifo2_rd_data_vld,
  output logic [23:0]      o_rgb,
  output logic             o_rgb_vld,
  input  logic             i_rgb_ready,
  output logic             o_line_end,
  output logic             o_frame_end,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_underrun_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(LINE_PIXELS - 1);
  localparam logic [CNT_W-1:0] LINE_LEN  = CNT_W'(LINE_PIXELS);
  localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(FRAME_LINES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_sel;        // 0 = fifo1, 1 = fifo2
  logic             r_rd_pend;    // read issued last cycle, data due now
  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] r_pix_cnt;
  logic [CNT_W-1:0] r_line_cnt;
  logic [CNT_W-1:0] r_underrun;
  logic [1:0]       r_occ;
  logic [23:0]      r_head;
  logic [23:0]      r_tail;

  logic             w_sel_empty;
  logic             w_sel_vld;
  logic [15:0]      w_sel_data;
  logic [23:0]      w_rgb_in;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_used;
  logic             w_room;
  logic             w_issue;
  logic             w_last_issue;
  logic             w_line_done;
  logic             w_frame_done;
  logic             w_next_line;
  logic             w_start;
  logic             w_underrun_hit;

  assign w_sel_empty = r_sel ? i_fifo2_empty       : i_fifo1_empty;
  assign w_sel_vld   = r_sel ? i_fifo2_rd_data_vld : i_fifo1_rd_data_vld;
  assign w_sel_data  = r_sel ? i_fifo2_rd_data     : i_fifo1_rd_data;

  assign w_rgb_in = {w_sel_data[15:11], w_sel_data[15:13],
                     w_sel_data[10:5],  w_sel_data[10:9],
                     w_sel_data[4:0],   w_sel_data[4:2]};

  assign w_push = w_sel_vld & (r_state != S_IDLE);
  assign w_pop  = (r_occ != 2'd0) & i_rgb_ready;

  // A slot freed by this cycle's pop counts as room, which keeps 1 pixel/clk.
  assign w_used = r_occ + {1'b0, r_rd_pend};
  assign w_room = (w_used - {1'b0, w_pop}) < 2'd2;

  assign w_issue = (r_state == S_READ) & ~w_sel_empty & i_work_en & w_room &
                   (r_issued < LINE_LEN);
  assign w_last_issue = w_issue & (r_issued == LAST_PIX);

  assign w_line_done  = (r_state == S_DRAIN) & w_pop & (r_pix_cnt == LAST_PIX);
  assign w_frame_done = w_line_done & (r_line_cnt == LAST_LINE);
  assign w_next_line  = w_line_done & ~w_frame_done;
  assign w_start      = (r_state == S_IDLE) & i_frame_start;

  assign w_underrun_hit = (r_state == S_READ) & w_sel_empty & (r_occ == 2'd0) &
                          ~r_rd_pend & i_work_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_frame_start) w_state_next = S_READ;
      S_READ:  if (w_last_issue) w_state_next = S_DRAIN;
      S_DRAIN: if (w_line_done) w_state_next = w_frame_done ? S_IDLE : S_READ;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_fifo1_rd_en = w_issue & ~r_sel;
    o_fifo2_rd_en = w_issue & r_sel;
    o_line_end    = w_line_done;
    o_frame_end   = w_frame_done;
    o_busy        = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel      <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_issued   <= '0;
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
      r_underrun <= '0;
    end else begin
      r_rd_pend <= w_issue;
      if (w_start) begin
        r_sel      <= 1'b0;
        r_issued   <= '0;
        r_pix_cnt  <= '0;
        r_line_cnt <= '0;
        r_underrun <= '0;
      end else begin
        if (w_issue) begin
          r_issued <= r_issued + CNT_ONE;
        end else if (w_next_line) begin
          r_sel      <= ~r_sel;
          r_issued   <= '0;
          r_line_cnt <= r_line_cnt + CNT_ONE;
        end
        if (w_pop) begin
          r_pix_cnt <= (r_pix_cnt == LAST_PIX) ? '0 : r_pix_cnt + CNT_ONE;
        end
        if (w_underrun_hit && (r_underrun != '1)) begin
          r_underrun <= r_underrun + CNT_ONE;
        end
      end
    end
  end

  // Head always holds the oldest pixel so o_rgb comes straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ  <= 2'd0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_head <= w_rgb_in;
          else               r_tail <= w_rgb_in;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          if (r_occ == 2'd2) r_head <= r_tail;
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_head <= w_rgb_in;
          end else begin
            r_head <= r_tail;
            r_tail <= w_rgb_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rgb          = r_head;
  assign o_rgb_vld      = (r_occ != 2'd0);
  assign o_underrun_cnt = r_underrun;

endmodule

// File: tb/tb_pingpong_fifo_reader.sv
// Directed bench for pingpong_fifo_reader with 4-pixel lines and 2-line frames.
module tb_pingpong_fifo_reader;
  localparam int LP = 4;
  localparam int FL = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          work_en = 1'b1;
  logic          rgb_ready = 1'b1;
  logic          f1_empty, f2_empty;
  logic          f1_vld = 1'b0, f2_vld = 1'b0;
  logic [15:0]   f1_data = 16'h0, f2_data = 16'h0;
  logic          rd1, rd2;
  logic [23:0]   rgb;
  logic          rgb_vld, line_end, frame_end, busy;
  logic [CW-1:0] underrun;

  logic [15:0]   mem1 [16];
  logic [15:0]   mem2 [16];
  logic [4:0]    wp1 = 5'd0, rp1 = 5'd0, wp2 = 5'd0, rp2 = 5'd0;

  int checks = 0;
  int failures = 0;

  logic [23:0] acc_rgb [16];
  int          acc_cyc [16];
  logic        acc_le  [16];
  logic        acc_fe  [16];
  int n_acc, n_rd, first_rd_cyc, first_vld_cyc, both_cnt, rd_empty_cnt;
  int rd_we_off, stall_viol, stall_seen, stray_end, max_out, end_cyc;
  logic first_rd_src, done;
  logic [23:0] exp_px [8];

  always #5 clk = ~clk;

  pingpong_fifo_reader #(.LINE_PIXELS(LP), .FRAME_LINES(FL), .CNT_W(CW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_frame_start       (frame_start),
    .i_work_en           (work_en),
    .i_fifo1_empty       (f1_empty),
    .o_fifo1_rd_en       (rd1),
    .i_fifo1_rd_data     (f1_data),
    .i_fifo1_rd_data_vld (f1_vld),
    .i_fifo2_empty       (f2_empty),
    .o_fifo2_rd_en       (rd2),
    .i_fifo2_rd_data     (f2_data),
    .i_fifo2_rd_data_vld (f2_vld),
    .o_rgb               (rgb),
    .o_rgb_vld           (rgb_vld),
    .i_rgb_ready         (rgb_ready),
    .o_line_end          (line_end),
    .o_frame_end         (frame_end),
    .o_busy              (busy),
    .o_underrun_cnt      (underrun)
  );

  // Source FIFO models: data and valid one cycle after rd_en.
  assign f1_empty = (wp1 == rp1);
  assign f2_empty = (wp2 == rp2);

  always @(posedge clk) begin
    if (rd1) begin
      f1_data <= mem1[rp1[3:0]];
      rp1     <= rp1 + 5'd1;
      f1_vld  <= 1'b1;
    end else begin
      f1_vld  <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rd2) begin
      f2_data <= mem2[rp2[3:0]];
      rp2     <= rp2 + 5'd1;
      f2_vld  <= 1'b1;
    end else begin
      f2_vld  <= 1'b0;
    end
  end

  task automatic push1(input logic [15:0] d);
    mem1[wp1[3:0]] = d;
    wp1 = wp1 + 5'd1;
  endtask

  task automatic push2(input logic [15:0] d);
    mem2[wp2[3:0]] = d;
    wp2 = wp2 + 5'd1;
  endtask

  task automatic load_std();
    push1(16'hF800); push1(16'h07E0); push1(16'h001F); push1(16'hFFFF);
    push2(16'h1234); push2(16'h5678); push2(16'h9ABC); push2(16'hDEF0);
    exp_px[0] = 24'hFF0000; exp_px[1] = 24'h00FF00;
    exp_px[2] = 24'h0000FF; exp_px[3] = 24'hFFFFFF;
    exp_px[4] = 24'h1045A5; exp_px[5] = 24'h52CFC6;
    exp_px[6] = 24'h9C55E7; exp_px[7] = 24'hDEDF84;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frame_start = 1'b0;
    work_en = 1'b1;
    rgb_ready = 1'b1;
    repeat (2) @(posedge clk);
    wp1 = rp1;
    wp2 = rp2;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Pulses frame_start, then observes one cycle per iteration (cycle 0 = first READ cycle).
  task automatic run_frame(input int max_cyc, input logic [3:0] rdy_pat, input int gap_len,
                           input int fs_again, input int stop_at_acc);
    int gap_left;
    logic gap_done;
    logic prev_stall;
    logic [23:0] prev_rgb;
    n_acc = 0; n_rd = 0; first_rd_cyc = -1; first_vld_cyc = -1; both_cnt = 0;
    rd_empty_cnt = 0; rd_we_off = 0; stall_viol = 0; stall_seen = 0; stray_end = 0;
    max_out = 0; end_cyc = -1; done = 1'b0; first_rd_src = 1'b0;
    gap_left = 0; gap_done = 1'b0; prev_stall = 1'b0; prev_rgb = 24'h0;
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      rgb_ready = rdy_pat[c % 4];
      frame_start = (c == fs_again);
      if (gap_left > 0) begin
        work_en = 1'b0;
        gap_left--;
      end else begin
        work_en = 1'b1;
      end
      @(negedge clk);
      if (rd1 && rd2) both_cnt++;
      if ((rd1 && f1_empty) || (rd2 && f2_empty)) rd_empty_cnt++;
      if (rd1 || rd2) begin
        if (first_rd_cyc < 0) begin
          first_rd_cyc = c;
          first_rd_src = rd2;
        end
        n_rd++;
        if (!work_en) rd_we_off++;
        if (gap_len > 0 && !gap_done && n_rd == 2) begin
          gap_left = gap_len;
          gap_done = 1'b1;
        end
      end
      if (rgb_vld && first_vld_cyc < 0) first_vld_cyc = c;
      if (prev_stall && (!rgb_vld || rgb !== prev_rgb)) stall_viol++;
      if (rgb_vld && rgb_ready) begin
        if (n_acc < 16) begin
          acc_rgb[n_acc] = rgb;
          acc_cyc[n_acc] = c;
          acc_le[n_acc]  = line_end;
          acc_fe[n_acc]  = frame_end;
        end
        n_acc++;
      end else if (line_end || frame_end) begin
        stray_end++;
      end
      prev_stall = rgb_vld && !rgb_ready;
      if (prev_stall) stall_seen++;
      prev_rgb = rgb;
      if (n_rd - n_acc > max_out) max_out = n_rd - n_acc;
      if (stop_at_acc > 0 && n_acc == stop_at_acc) break;
      if (!busy) begin
        done = 1'b1;
        end_cyc = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    frame_start = 1'b0;
    work_en = 1'b1;
    rgb_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    frame_start = 1'b0;
    work_en = 1'b1;
    rgb_ready = 1'b1;
    wp1 = rp1;
    wp2 = rp2;
    @(negedge clk);
    checks++;
    if ({rd1, rd2, rgb_vld, line_end, frame_end, busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000000", {rd1, rd2, rgb_vld, line_end, frame_end, busy});
    end
    checks++;
    if (rgb !== 24'h0) begin
      failures++;
      $display("FAIL reset_rgb got=%h exp=000000", rgb);
    end
    checks++;
    if (underrun !== 16'h0) begin
      failures++;
      $display("FAIL reset_underrun got=%0d exp=0", underrun);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy got=%b exp=0", busy);
    end
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (underrun !== 16'(k)) begin
        failures++;
        $display("FAIL underrun_cyc%0d got=%0d exp=%0d", k, underrun, k);
      end
      checks++;
      if (busy !== 1'b1 || rd1 !== 1'b0 || rd2 !== 1'b0) begin
        failures++;
        $display("FAIL empty_no_rd_cyc%0d got busy=%b rd1=%b rd2=%b exp 1 0 0", k, busy, rd1, rd2);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_two_lines();
    do_reset();
    push1(16'hF800); push1(16'h07E0); push1(16'h001F); push1(16'hFFFF);
    for (int i = 0; i < 4; i++) push2(16'h0000);
    exp_px[0] = 24'hFF0000; exp_px[1] = 24'h00FF00;
    exp_px[2] = 24'h0000FF; exp_px[3] = 24'hFFFFFF;
    for (int i = 4; i < 8; i++) exp_px[i] = 24'h000000;
    run_frame(60, 4'hF, 0, -1, 0);
    checks++;
    if (!done || end_cyc != 12) begin
      failures++;
      $display("FAIL t2_busy_drop got done=%b cyc=%0d exp done=1 cyc=12", done, end_cyc);
    end
    checks++;
    if (n_acc != 8) begin
      failures++;
      $display("FAIL t2_count got=%0d exp=8", n_acc);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (acc_rgb[i] !== exp_px[i] || acc_le[i] !== (i == 3 || i == 7) || acc_fe[i] !== (i == 7)) begin
        failures++;
        $display("FAIL t2_pix%0d got rgb=%h le=%b fe=%b exp rgb=%h le=%b fe=%b", i, acc_rgb[i],
                 acc_le[i], acc_fe[i], exp_px[i], (i == 3 || i == 7), (i == 7));
      end
    end
    checks++;
    if (acc_cyc[0] != 2 || acc_cyc[1] != 3 || acc_cyc[2] != 4 || acc_cyc[3] != 5) begin
      failures++;
      $display("FAIL t2_back_to_back got=%0d,%0d,%0d,%0d exp=2,3,4,5", acc_cyc[0], acc_cyc[1],
               acc_cyc[2], acc_cyc[3]);
    end
    checks++;
    if (first_rd_cyc != 0 || first_vld_cyc != 2) begin
      failures++;
      $display("FAIL t2_latency got rd=%0d vld=%0d exp rd=0 vld=2", first_rd_cyc, first_vld_cyc);
    end
    checks++;
    if (both_cnt != 0 || rd_empty_cnt != 0 || stray_end != 0) begin
      failures++;
      $display("FAIL t2_strobes got both=%0d rd_empty=%0d stray=%0d exp 0 0 0", both_cnt,
               rd_empty_cnt, stray_end);
    end
    checks++;
    if (underrun !== 16'h0 || !f1_empty || !f2_empty) begin
      failures++;
      $display("FAIL t2_final got underrun=%0d e1=%b e2=%b exp 0 1 1", underrun, f1_empty, f2_empty);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    load_std();
    run_frame(120, 4'b1001, 0, -1, 0);
    checks++;
    if (!done || n_acc != 8) begin
      failures++;
      $display("FAIL t3_count got done=%b n=%0d exp done=1 n=8", done, n_acc);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (acc_rgb[i] !== exp_px[i]) begin
        failures++;
        $display("FAIL t3_pix%0d got=%h exp=%h", i, acc_rgb[i], exp_px[i]);
      end
    end
    checks++;
    if (stall_seen == 0 || stall_viol != 0) begin
      failures++;
      $display("FAIL t3_stall got seen=%0d viol=%0d exp seen>0 viol=0", stall_seen, stall_viol);
    end
    checks++;
    if (max_out > 2 || both_cnt != 0 || rd_empty_cnt != 0) begin
      failures++;
      $display("FAIL t3_credit got max_out=%0d both=%0d rd_empty=%0d exp <=2 0 0", max_out,
               both_cnt, rd_empty_cnt);
    end
  endtask

  task automatic test_work_en_gap();
    do_reset();
    load_std();
    run_frame(80, 4'hF, 5, -1, 0);
    checks++;
    if (rd_we_off != 0) begin
      failures++;
      $display("FAIL t4_rd_while_off got=%0d exp=0", rd_we_off);
    end
    checks++;
    if (!done || n_acc != 8) begin
      failures++;
      $display("FAIL t4_count got done=%b n=%0d exp done=1 n=8", done, n_acc);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (acc_rgb[i] !== exp_px[i]) begin
        failures++;
        $display("FAIL t4_pix%0d got=%h exp=%h", i, acc_rgb[i], exp_px[i]);
      end
    end
    checks++;
    if (acc_cyc[1] != 3 || acc_cyc[2] != 9) begin
      failures++;
      $display("FAIL t4_resume got cyc1=%0d cyc2=%0d exp 3 9", acc_cyc[1], acc_cyc[2]);
    end
    checks++;
    if (underrun !== 16'h0) begin
      failures++;
      $display("FAIL t4_underrun got=%0d exp=0", underrun);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    load_std();
    run_frame(60, 4'hF, 0, -1, 5);
    checks++;
    if (n_acc != 5 || acc_rgb[4] !== 24'h1045A5) begin
      failures++;
      $display("FAIL t5_pre got n=%0d px4=%h exp n=5 px4=1045a5", n_acc, acc_rgb[4]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rd1, rd2, rgb_vld, line_end, frame_end, busy} !== 6'b0 || rgb !== 24'h0 ||
        underrun !== 16'h0) begin
      failures++;
      $display("FAIL t5_async_reset got flags=%b rgb=%h underrun=%0d exp 000000 000000 0",
               {rd1, rd2, rgb_vld, line_end, frame_end, busy}, rgb, underrun);
    end
    wp1 = rp1;
    wp2 = rp2;
    push1(16'h9ABC); push1(16'hDEF0); push1(16'h1234); push1(16'h5678);
    push2(16'hF800); push2(16'h07E0); push2(16'h001F); push2(16'hFFFF);
    exp_px[0] = 24'h9C55E7; exp_px[1] = 24'hDEDF84;
    exp_px[2] = 24'h1045A5; exp_px[3] = 24'h52CFC6;
    exp_px[4] = 24'hFF0000; exp_px[5] = 24'h00FF00;
    exp_px[6] = 24'h0000FF; exp_px[7] = 24'hFFFFFF;
    @(posedge clk); #1 rst_n = 1'b1;
    run_frame(60, 4'hF, 0, -1, 0);
    checks++;
    if (first_rd_cyc != 0 || first_rd_src !== 1'b0) begin
      failures++;
      $display("FAIL t5_restart_sel got cyc=%0d src=%b exp cyc=0 src=0", first_rd_cyc, first_rd_src);
    end
    checks++;
    if (!done || n_acc != 8) begin
      failures++;
      $display("FAIL t5_count got done=%b n=%0d exp done=1 n=8", done, n_acc);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (acc_rgb[i] !== exp_px[i] || acc_le[i] !== (i == 3 || i == 7) || acc_fe[i] !== (i == 7)) begin
        failures++;
        $display("FAIL t5_pix%0d got rgb=%h le=%b fe=%b exp rgb=%h le=%b fe=%b", i, acc_rgb[i],
                 acc_le[i], acc_fe[i], exp_px[i], (i == 3 || i == 7), (i == 7));
      end
    end
  endtask

  task automatic test_frame_start_ignored();
    do_reset();
    load_std();
    run_frame(60, 4'hF, 0, 7, 0);
    checks++;
    if (!done || n_acc != 8) begin
      failures++;
      $display("FAIL t6_count got done=%b n=%0d exp done=1 n=8", done, n_acc);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (acc_rgb[i] !== exp_px[i]) begin
        failures++;
        $display("FAIL t6_pix%0d got=%h exp=%h", i, acc_rgb[i], exp_px[i]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rd1 !== 1'b0 || rd2 !== 1'b0) begin
        failures++;
        $display("FAIL t6_idle%0d got busy=%b rd1=%b rd2=%b exp 0 0 0", k, busy, rd1, rd2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_lines();
    test_backpressure();
    test_work_en_gap();
    test_reset_mid_frame();
    test_frame_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
